// File: rtl/fp9_pkg.sv
// Shared types and constants for the 9-bit minifloat {sign, exp[3:0], fract[3:0]}, bias 7.
package fp9_pkg;

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [3:0] fract;
  } fp9_t;

  localparam int EXP_BIAS = 7;
  localparam int EXP_INF  = 15;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } seq_state_t;

endpackage

// File: rtl/fp_operand_swap.sv
// Orders an operand pair by magnitude and derives result sign, effective operation and alignment distance.
module fp_operand_swap #(
  parameter int EXP_W     = 4,
  parameter int FRAC_W    = 4,
  parameter int MAX_ALIGN = 5,
  parameter int CNT_W     = 3
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic                  op_sub,
  output logic [EXP_W-1:0]      exp_big,
  output logic [FRAC_W+1:0]     sig_big,
  output logic [FRAC_W+1:0]     sig_small,
  output logic                  sign_res,
  output logic                  eff_sub,
  output logic [CNT_W-1:0]      n_align,
  output logic                  inf_in
);

  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b, exp_small, diff;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic [FRAC_W+1:0] sig_a, sig_b;
  logic              a_big;

  assign sign_a = a[EXP_W+FRAC_W];
  assign sign_b = b[EXP_W+FRAC_W] ^ op_sub;
  assign exp_a  = a[EXP_W+FRAC_W-1:FRAC_W];
  assign exp_b  = b[EXP_W+FRAC_W-1:FRAC_W];
  assign frac_a = a[FRAC_W-1:0];
  assign frac_b = b[FRAC_W-1:0];

  // A zero exponent means a true zero: the stored fraction is ignored entirely.
  assign sig_a = (exp_a == '0) ? '0 : {2'b01, frac_a};
  assign sig_b = (exp_b == '0) ? '0 : {2'b01, frac_b};

  assign a_big = (exp_a > exp_b) || ((exp_a == exp_b) && (frac_a >= frac_b));

  assign exp_big   = a_big ? exp_a : exp_b;
  assign exp_small = a_big ? exp_b : exp_a;
  assign sig_big   = a_big ? sig_a : sig_b;
  assign sig_small = a_big ? sig_b : sig_a;
  assign sign_res  = a_big ? sign_a : sign_b;
  assign eff_sub   = sign_a ^ sign_b;
  assign inf_in    = (&exp_a) || (&exp_b);

  assign diff    = exp_big - exp_small;
  assign n_align = (diff > EXP_W'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : CNT_W'(diff);

endmodule

// File: rtl/fp9_addsub_sequencer.sv
// Multi-cycle minifloat add/subtract: order, align 1 bit/cycle, add, normalise iteratively, pack.
module fp9_addsub_sequencer
  import fp9_pkg::*;
#(
  parameter int EXP_W     = 4,
  parameter int FRAC_W    = 4,
  parameter int MAX_ALIGN = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  ovf,
  output logic                  unf,
  output logic                  busy
);

  localparam int W  = EXP_W + FRAC_W + 1;
  localparam int SW = FRAC_W + 2;
  localparam int XW = EXP_W + 2;  // two's-complement headroom for exp+1 and exp going below 1
  localparam int CW = $clog2(MAX_ALIGN + 1);

  seq_state_t     state, state_n;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  sig_q, small_q, norm_sig;
  logic [XW-1:0]  exp_q, norm_exp;
  logic           sign_q, eff_sub_q, inf_q, norm_done;
  logic [W-1:0]   result_q, pack_result;
  logic           ovf_q, unf_q, pack_ovf, pack_unf;

  logic [EXP_W-1:0] sw_exp_big;
  logic [SW-1:0]    sw_sig_big, sw_sig_small;
  logic             sw_sign, sw_eff_sub, sw_inf;
  logic [CW-1:0]    sw_n_align;

  fp_operand_swap #(
    .EXP_W(EXP_W), .FRAC_W(FRAC_W), .MAX_ALIGN(MAX_ALIGN), .CNT_W(CW)
  ) u_swap (
    .a(a), .b(b), .op_sub(op_sub),
    .exp_big(sw_exp_big), .sig_big(sw_sig_big), .sig_small(sw_sig_small),
    .sign_res(sw_sign), .eff_sub(sw_eff_sub), .n_align(sw_n_align), .inf_in(sw_inf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    norm_sig  = sig_q;
    norm_exp  = exp_q;
    norm_done = 1'b0;
    if (sig_q == '0) begin
      norm_done = 1'b1;
    end else if (sig_q[SW-1]) begin
      norm_sig  = sig_q >> 1;
      norm_exp  = exp_q + XW'(1);
      norm_done = 1'b1;
    end else if (sig_q[SW-2]) begin
      norm_done = 1'b1;
    end else begin
      norm_sig = sig_q << 1;
      norm_exp = exp_q - XW'(1);
    end

    unique case (state)
      IDLE:    if (in_valid) state_n = (sw_n_align != '0) ? ALIGN : ADD;
      ALIGN:   if (cnt == CW'(1)) state_n = ADD;
      ADD:     state_n = NORM;
      NORM:    if (norm_done) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Exception resolution on the values that will be held in DONE; overflow outranks cancellation.
  always_comb begin
    pack_result = {sign_q, norm_exp[EXP_W-1:0], norm_sig[FRAC_W-1:0]};
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    if (inf_q || (!norm_exp[XW-1] && (norm_exp >= XW'(EXP_INF)))) begin
      pack_result = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      pack_ovf    = 1'b1;
    end else if (norm_sig == '0) begin
      pack_result = '0;
    end else if (norm_exp[XW-1] || (norm_exp == '0)) begin
      pack_result = '0;
      pack_unf    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sig_q     <= '0;
      small_q   <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      inf_q     <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          sig_q     <= sw_sig_big;
          small_q   <= sw_sig_small;
          exp_q     <= XW'(sw_exp_big);
          sign_q    <= sw_sign;
          eff_sub_q <= sw_eff_sub;
          inf_q     <= sw_inf;
          cnt       <= sw_n_align;
        end
        ALIGN: begin
          small_q <= small_q >> 1;
          cnt     <= cnt - CW'(1);
        end
        ADD: sig_q <= eff_sub_q ? (sig_q - small_q) : (sig_q + small_q);
        NORM: begin
          sig_q <= norm_sig;
          exp_q <= norm_exp;
          if (norm_done) begin
            result_q <= pack_result;
            ovf_q    <= pack_ovf;
            unf_q    <= pack_unf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_fp9_addsub_sequencer.sv
// Directed scoreboard bench for fp9_addsub_sequencer: results, flags, latency, hold and reset behaviour.
module tb_fp9_addsub_sequencer;
  import fp9_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [8:0] a = '0, b = '0;
  logic       in_ready, out_valid, ovf, unf, busy;
  logic [8:0] result;

  typedef struct {
    logic [8:0] res;
    logic       ovf;
    logic       unf;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fp9_addsub_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .unf(unf), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one operation, wait for its result, compare against the scoreboard, optionally stall writeback.
  task automatic do_op(input string tag, input logic [8:0] ta, input logic [8:0] tb_op,
                       input logic sub, input logic [8:0] e_res, input logic e_ovf,
                       input logic e_unf, input int e_lat, input int hold);
    exp_t e;
    fp9_t held;
    int   lat;
    sb.push_back('{res: e_res, ovf: e_ovf, unf: e_unf, lat: e_lat});
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_op; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 9'($urandom); b = 9'($urandom); op_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({tag, "_result"},  32'(result), 32'(e.res));
    check({tag, "_ovf"},     32'(ovf), 32'(e.ovf));
    check({tag, "_unf"},     32'(unf), 32'(e.unf));
    held = fp9_t'(e.res);
    for (int i = 0; i < hold; i++) begin
      a = 9'h070; b = 9'h070; in_valid = (i % 2) == 0;
      @(posedge clk); #1;
      check({tag, "_hold_valid"},  32'(out_valid), 32'd1);
      check({tag, "_hold_ready"},  32'(in_ready), 32'd0);
      check({tag, "_hold_result"}, 32'(result), 32'(held));
      check({tag, "_hold_ovf"},    32'(ovf), 32'(e.ovf));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  initial begin
    #12;
    check("reset_state", 32'({out_valid, in_ready, busy, ovf, unf}), 32'b01000);
    check("reset_result", 32'(result), 32'h000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_op("one_plus_one",  9'h070, 9'h070, 1'b0, 9'h080, 1'b0, 1'b0, 2, 0);
    do_op("align_two",     9'h070, 9'h050, 1'b0, 9'h074, 1'b0, 1'b0, 4, 0);
    // Four left shifts plus the final hidden-bit check make five NORM cycles.
    do_op("left_shift4",   9'h071, 9'h070, 1'b1, 9'h030, 1'b0, 1'b0, 6, 0);
    do_op("cancel",        9'h078, 9'h078, 1'b1, 9'h000, 1'b0, 1'b0, 2, 0);
    do_op("carry_ovf",     9'h0EF, 9'h0EF, 1'b0, 9'h0F0, 1'b1, 1'b0, 2, 0);
    do_op("underflow",     9'h011, 9'h010, 1'b1, 9'h000, 1'b0, 1'b1, 6, 0);
    do_op("neg_inf",       9'h1F0, 9'h070, 1'b0, 9'h1F0, 1'b1, 1'b0, 7, 0);
    do_op("sub_negative",  9'h070, 9'h170, 1'b1, 9'h080, 1'b0, 1'b0, 2, 0);
    do_op("mixed_sign",    9'h170, 9'h060, 1'b0, 9'h160, 1'b0, 1'b0, 4, 0);
    do_op("b_larger",      9'h050, 9'h070, 1'b1, 9'h168, 1'b0, 1'b0, 5, 0);
    do_op("zero_operand",  9'h000, 9'h07F, 1'b0, 9'h07F, 1'b0, 1'b0, 7, 0);
    do_op("truncate",      9'h070, 9'h03F, 1'b0, 9'h071, 1'b0, 1'b0, 6, 0);
    do_op("hold_done",     9'h0EF, 9'h0EF, 1'b0, 9'h0F0, 1'b1, 1'b0, 2, 5);

    // Asynchronous reset in the middle of alignment.
    a = 9'h070; b = 9'h050; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_align_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", 32'({out_valid, in_ready, busy}), 32'b010);
    check("async_rst_result", 32'(result), 32'h000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_op("after_reset",   9'h070, 9'h050, 1'b0, 9'h074, 1'b0, 1'b0, 4, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
